guess_entry: RTL and testbench
==============================

Name: guess_entry

Overview:
Player guess-entry register file for the code-breaking game.
- Holds NUM_SLOTS colour slots and a cursor, edited by debounced button pulses.
- Colour values wrap at an arbitrary NUM_COLORS.
- Hands the finished guess to the scoring block over a valid/ready handshake, then freezes until scoring completes.
- Sits between the button debouncers and the guess checker.

Parameters:
- NUM_SLOTS, 4, number of colour slots (2..8).
- COLOR_W, 3, bits per slot.
- NUM_COLORS, 6, legal colours 0..NUM_COLORS-1; must satisfy 2 <= NUM_COLORS <= 2**COLOR_W.
- SEL_W, $clog2(NUM_SLOTS), localparam, cursor width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  game active; gates all button inputs in EDIT
- left  in  1  one-cycle pulse: cursor -1
- right  in  1  one-cycle pulse: cursor +1
- up  in  1  one-cycle pulse: selected colour +1
- down  in  1  one-cycle pulse: selected colour -1
- clear  in  1  one-cycle pulse: zero all slots and cursor
- submit  in  1  one-cycle pulse: offer guess to checker
- guess  out  NUM_SLOTS*COLOR_W  slot i at [i*COLOR_W +: COLOR_W]
- sel  out  SEL_W  cursor position
- editing  out  1  high in EDIT state
- guess_valid  out  1  guess offered to checker
- guess_ready  in  1  checker accepts
- result_done  in  1  one-cycle pulse: scoring finished
- dup_err  out  1  one-cycle pulse: submit rejected (optional feature)

Behaviour:
- Reset: all slots 0, sel 0, state EDIT, guess_valid 0, dup_err 0, editing 1.
- All outputs are registered. Every effect is visible on the cycle after the input pulse.
- States:
  - EDIT: editing=1, guess_valid=0.
  - OFFER: guess_valid=1.
  - WAIT: both 0.
- EDIT, enable=1, per-cycle priority:
  - clear: all slots 0, sel 0. All other pulses that cycle are ignored.
  - else submit: go to OFFER. Edits that cycle are ignored.
  - else edits:
    - Cursor: right -> sel+1, wrapping NUM_SLOTS-1 -> 0. left -> sel-1, wrapping 0 -> NUM_SLOTS-1. Wrap is explicit, so it is correct for non-power-of-2 NUM_SLOTS.
    - Colour: up -> slot[sel]+1, wrapping NUM_COLORS-1 -> 0. down -> slot[sel]-1, wrapping 0 -> NUM_COLORS-1.
    - left and right together: cursor unchanged. up and down together: colour unchanged.
    - A colour change in the same cycle as a cursor move targets the pre-move sel.
- EDIT, enable=0: all pulses ignored; state held.
- OFFER:
  - guess and sel frozen. All buttons and enable ignored; guess_valid never drops without a handshake.
  - On guess_valid && guess_ready: go to WAIT; guess_valid=0 on the next cycle.
  - guess_ready may be held high; acceptance takes a single cycle.
- WAIT:
  - Buttons ignored; guess held.
  - On result_done: go to EDIT. Slots and sel are retained, so the player edits the previous guess.
- result_done in EDIT or OFFER is ignored.
- Slot values never leave 0..NUM_COLORS-1 by construction.
- rst in any state, including mid-handshake, forces the reset values on the next edge. The checker tolerates guess_valid dropping under reset.

Optional Feature:
- Macro: GUESS_DUP_CHECK_EN.
- With it:
  - A submit in EDIT while any two slots hold equal colours is rejected: state stays EDIT and dup_err pulses high for one cycle.
  - clear still has priority over submit.
- Without it: dup_err is tied 0 and any guess is accepted.

Decomposition:
- Package guess_pkg:
  - State enum typedef (EDIT, OFFER, WAIT).
  - Default COLOR_W/NUM_COLORS/NUM_SLOTS constants.
  - Functions wrap_inc(val, max) and wrap_dec(val, max).
- Sub-module guess_dup_detect: combinational pairwise slot comparator producing a single dup flag. Instantiated only under GUESS_DUP_CHECK_EN.

Test Plan:
- Reset, then right x5 with NUM_SLOTS=4 -> sel sequence 1,2,3,0,1. Reset, then left x1 -> sel=3.
- sel=0, up x6 with NUM_COLORS=6 -> slot0 = 1..5, then 0. down x1 from 0 -> 5. Other slots unchanged.
- Pulse up and right together at sel=1, slot1=2 -> slot1=3, sel=2, one cycle later.
- submit with guess_ready=0 for 3 cycles, then 1 -> guess_valid high 4 cycles. Button pulses during OFFER have no effect. guess_valid and editing are 0 in WAIT. result_done -> editing=1, slots and sel unchanged.
- Slots {2,2,4,1}, submit (with GUESS_DUP_CHECK_EN) -> dup_err single-cycle pulse, guess_valid stays 0. Slots {2,3,4,1}, submit -> guess_valid=1.
- clear and submit together in EDIT -> all slots 0, sel 0, no guess_valid. rst asserted during OFFER -> guess_valid 0 and state EDIT the next cycle.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types, default sizes and wrap-around arithmetic for the guess-entry block.
// Combinational helpers only; no latency or backpressure of its own.
package guess_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    OFFER = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int DEF_NUM_SLOTS  = 4;
  localparam int DEF_COLOR_W    = 3;
  localparam int DEF_NUM_COLORS = 6;

  // Wrap explicitly at max so non-power-of-2 ranges behave correctly.
  function automatic int wrap_inc(input int val, input int max);
    return (val >= max - 1) ? 0 : val + 1;
  endfunction

  function automatic int wrap_dec(input int val, input int max);
    return (val == 0) ? max - 1 : val - 1;
  endfunction

endpackage

// File: rtl/guess_dup_detect.sv
// Pairwise slot comparator: flags when any two slots hold the same colour.
// Purely combinational, zero latency; no backpressure.
module guess_dup_detect
  import guess_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int COLOR_W   = DEF_COLOR_W
) (
  input  logic [NUM_SLOTS*COLOR_W-1:0] guess,
  output logic                         dup
);

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (guess[i*COLOR_W +: COLOR_W] == guess[j*COLOR_W +: COLOR_W]) dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Guess-entry register file: button-edited colour slots, offered to the checker by valid/ready.
// Latency: every effect registered, visible one cycle after the pulse; duplicate rejection under GUESS_DUP_CHECK_EN.
// Backpressure: guess_valid holds until guess_ready, then the block freezes until result_done.
module guess_entry
  import guess_pkg::*;
#(
  parameter int  NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int  COLOR_W    = DEF_COLOR_W,
  parameter int  NUM_COLORS = DEF_NUM_COLORS,
  localparam int SEL_W      = $clog2(NUM_SLOTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         left,
  input  logic                         right,
  input  logic                         up,
  input  logic                         down,
  input  logic                         clear,
  input  logic                         submit,
  output logic [NUM_SLOTS*COLOR_W-1:0] guess,
  output logic [SEL_W-1:0]             sel,
  output logic                         editing,
  output logic                         guess_valid,
  input  logic                         guess_ready,
  input  logic                         result_done,
  output logic                         dup_err
);

  state_t             state, state_nxt;
  logic [COLOR_W-1:0] slot [NUM_SLOTS];
  logic               dup;
  logic               edit_live;
  logic               do_clear;
  logic               do_edit;
  logic               submit_try;

  assign edit_live  = (state == EDIT) && enable;
  assign do_clear   = edit_live && clear;
  assign submit_try = edit_live && !clear && submit;
  assign do_edit    = edit_live && !clear && !submit;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign guess[g*COLOR_W +: COLOR_W] = slot[g];
  end

`ifdef GUESS_DUP_CHECK_EN
  guess_dup_detect #(
    .NUM_SLOTS (NUM_SLOTS),
    .COLOR_W   (COLOR_W)
  ) u_dup (
    .guess (guess),
    .dup   (dup)
  );

  always_ff @(posedge clk) begin
    if (rst) dup_err <= 1'b0;
    else     dup_err <= submit_try && dup;
  end
`else
  assign dup     = 1'b0;
  assign dup_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      EDIT:    if (submit_try && !dup) state_nxt = OFFER;
      OFFER:   if (guess_ready)        state_nxt = WAIT;
      WAIT:    if (result_done)        state_nxt = EDIT;
      default: state_nxt = EDIT;
    endcase
  end

  // editing/guess_valid registered from the next state so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EDIT;
      editing     <= 1'b1;
      guess_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      editing     <= (state_nxt == EDIT);
      guess_valid <= (state_nxt == OFFER);
    end
  end

  // Colour edits address the pre-move cursor because both use the current sel.
  always_ff @(posedge clk) begin
    if (rst || do_clear) begin
      sel <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot[i] <= '0;
    end else if (do_edit) begin
      if (up && !down)
        slot[sel] <= COLOR_W'(wrap_inc(int'(slot[sel]), NUM_COLORS));
      else if (down && !up)
        slot[sel] <= COLOR_W'(wrap_dec(int'(slot[sel]), NUM_COLORS));
      if (right && !left)
        sel <= SEL_W'(wrap_inc(int'(sel), NUM_SLOTS));
      else if (left && !right)
        sel <= SEL_W'(wrap_dec(int'(sel), NUM_SLOTS));
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Bench for guess_entry: directed scenarios plus randomized run against a slot/cursor model.
module tb_guess_entry;

  localparam int NS = 4;
  localparam int CW = 3;
  localparam int NC = 6;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst, enable, left, right, up, down, clear, submit;
  logic          guess_ready, result_done;
  logic [NS*CW-1:0] guess;
  logic [SW-1:0] sel;
  logic          editing, guess_valid, dup_err;

  int tests = 0;
  int fails = 0;

  int m_slot [NS];
  int m_sel;
  int m_state;   // 0 edit, 1 offer, 2 wait
  int m_dup_err;

`ifdef GUESS_DUP_CHECK_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  guess_entry #(.NUM_SLOTS(NS), .COLOR_W(CW), .NUM_COLORS(NC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .left(left), .right(right),
    .up(up), .down(down), .clear(clear), .submit(submit),
    .guess(guess), .sel(sel), .editing(editing), .guess_valid(guess_valid),
    .guess_ready(guess_ready), .result_done(result_done), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {left, right, up, down, clear, submit} = '0;
    result_done = 1'b0;
  endtask

  // Buttons {clear, submit, left, right, up, down} for one cycle.
  task automatic press(input logic [5:0] b);
    {clear, submit, left, right, up, down} = b;
    tick();
    {clear, submit, left, right, up, down} = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; enable = 1'b1; guess_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_slots(input int v0, input int v1, input int v2, input int v3);
    int v [NS];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    press(6'b100000);
    for (int i = 0; i < NS; i++) begin
      for (int k = 0; k < v[i]; k++) press(6'b000010);
      press(6'b000100);
    end
  endtask

  function automatic logic [NS*CW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [NS*CW-1:0] r;
    r = '0;
    r[0 +: CW] = CW'(v0); r[CW +: CW] = CW'(v1);
    r[2*CW +: CW] = CW'(v2); r[3*CW +: CW] = CW'(v3);
    return r;
  endfunction

  function automatic bit m_has_dup();
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++)
        if (i != j && m_slot[i] == m_slot[j]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: next model state from the current inputs, straight from the game rules.
  task automatic m_step();
    int nsel;
    m_dup_err = 0;
    if (rst) begin
      foreach (m_slot[i]) m_slot[i] = 0;
      m_sel = 0; m_state = 0;
      return;
    end
    case (m_state)
      0: if (enable) begin
        if (clear) begin
          foreach (m_slot[i]) m_slot[i] = 0;
          m_sel = 0;
        end else if (submit) begin
          if (DUP_EN && m_has_dup()) m_dup_err = 1;
          else m_state = 1;
        end else begin
          if (up && !down) m_slot[m_sel] = (m_slot[m_sel] + 1) % NC;
          if (down && !up) m_slot[m_sel] = (m_slot[m_sel] + NC - 1) % NC;
          nsel = m_sel;
          if (right && !left) nsel = (m_sel + 1) % NS;
          if (left && !right) nsel = (m_sel + NS - 1) % NS;
          m_sel = nsel;
        end
      end
      1: if (guess_ready) m_state = 2;
      default: if (result_done) m_state = 0;
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (guess !== '0)      begin fails++; $display("FAIL reset_guess got %h want 0", guess); end
    tests++; if (sel !== '0)        begin fails++; $display("FAIL reset_sel got %0d want 0", sel); end
    tests++; if (editing !== 1'b1)  begin fails++; $display("FAIL reset_editing got %b want 1", editing); end
    tests++; if (guess_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", guess_valid); end
    tests++; if (dup_err !== 1'b0)  begin fails++; $display("FAIL reset_duperr got %b want 0", dup_err); end
  endtask

  task automatic test_cursor_wrap();
    int exp_sel [5] = '{1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(6'b000100);
      tests++;
      if (sel !== SW'(exp_sel[i])) begin fails++; $display("FAIL right_wrap step %0d got %0d want %0d", i, sel, exp_sel[i]); end
    end
    do_reset();
    press(6'b001000);
    tests++; if (sel !== SW'(3)) begin fails++; $display("FAIL left_wrap got %0d want 3", sel); end
  endtask

  task automatic test_color_wrap();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      press(6'b000010);
      tests++;
      if (guess[0 +: CW] !== CW'(i % NC)) begin fails++; $display("FAIL up_wrap step %0d got %0d want %0d", i, guess[0 +: CW], i % NC); end
    end
    press(6'b000001);
    tests++; if (guess[0 +: CW] !== CW'(5)) begin fails++; $display("FAIL down_wrap got %0d want 5", guess[0 +: CW]); end
    tests++; if (guess[NS*CW-1:CW] !== '0) begin fails++; $display("FAIL other_slots got %h want 0", guess[NS*CW-1:CW]); end
  endtask

  task automatic test_combo();
    do_reset();
    press(6'b000100);
    press(6'b000010);
    press(6'b000010);
    press(6'b000110);
    tests++; if (guess !== pack4(0, 3, 0, 0)) begin fails++; $display("FAIL combo_guess got %h want %h", guess, pack4(0, 3, 0, 0)); end
    tests++; if (sel !== SW'(2)) begin fails++; $display("FAIL combo_sel got %0d want 2", sel); end
    press(6'b001100);
    press(6'b000011);
    tests++; if (guess !== pack4(0, 3, 0, 0) || sel !== SW'(2)) begin fails++; $display("FAIL opposing_pulses got %h/%0d want %h/2", guess, sel, pack4(0, 3, 0, 0)); end
  endtask

  task automatic test_handshake();
    int cnt;
    logic [NS*CW-1:0] g0;
    do_reset();
    set_slots(1, 3, 5, 0);
    press(6'b000100);
    g0 = guess;
    press(6'b010000);
    cnt = 0;
    for (int k = 1; k <= 8 && guess_valid === 1'b1; k++) begin
      cnt++;
      guess_ready = (k >= 4);
      {left, right, up, down, clear, submit} = 6'b111111;
      enable = k[0];
      result_done = 1'b1;
      tick();
    end
    idle_inputs(); guess_ready = 1'b0; enable = 1'b1;
    tests++; if (cnt != 4) begin fails++; $display("FAIL offer_cycles got %0d want 4", cnt); end
    tests++; if (guess !== g0 || sel !== SW'(1)) begin fails++; $display("FAIL offer_frozen got %h/%0d want %h/1", guess, sel, g0); end
    tests++; if (guess_valid !== 1'b0 || editing !== 1'b0) begin fails++; $display("FAIL wait_flags got %b%b want 00", guess_valid, editing); end
    press(6'b101111);
    tests++; if (guess !== g0 || editing !== 1'b0) begin fails++; $display("FAIL wait_hold got %h/%b want %h/0", guess, editing, g0); end
    result_done = 1'b1; tick(); result_done = 1'b0;
    tests++; if (editing !== 1'b1 || guess !== g0 || sel !== SW'(1)) begin fails++; $display("FAIL done_return got %b/%h/%0d want 1/%h/1", editing, guess, sel, g0); end
  endtask

  task automatic finish_round();
    guess_ready = 1'b1; tick(); guess_ready = 1'b0;
    result_done = 1'b1; tick(); result_done = 1'b0;
  endtask

  task automatic test_dup();
    do_reset();
    set_slots(2, 2, 4, 1);
    press(6'b010000);
    tests++; if (dup_err !== DUP_EN) begin fails++; $display("FAIL dup_pulse got %b want %b", dup_err, DUP_EN); end
    tests++; if (guess_valid !== !DUP_EN) begin fails++; $display("FAIL dup_valid got %b want %b", guess_valid, !DUP_EN); end
    tick();
    tests++; if (dup_err !== 1'b0) begin fails++; $display("FAIL dup_single got %b want 0", dup_err); end
    if (!DUP_EN) finish_round();
    set_slots(2, 3, 4, 1);
    press(6'b010000);
    tests++; if (guess_valid !== 1'b1 || dup_err !== 1'b0) begin fails++; $display("FAIL nodup_valid got %b/%b want 1/0", guess_valid, dup_err); end
    finish_round();
  endtask

  task automatic test_clear_submit();
    do_reset();
    set_slots(1, 2, 3, 0);
    press(6'b000100);
    press(6'b110000);
    tests++; if (guess !== '0 || sel !== '0) begin fails++; $display("FAIL clear_submit got %h/%0d want 0/0", guess, sel); end
    tests++; if (guess_valid !== 1'b0 || editing !== 1'b1) begin fails++; $display("FAIL clear_submit_state got %b/%b want 0/1", guess_valid, editing); end
  endtask

  task automatic test_reset_offer();
    do_reset();
    set_slots(0, 1, 2, 3);
    press(6'b010000);
    tests++; if (guess_valid !== 1'b1) begin fails++; $display("FAIL pre_rst_valid got %b want 1", guess_valid); end
    guess_ready = 1'b1; rst = 1'b1; tick(); rst = 1'b0; guess_ready = 1'b0;
    tests++; if (guess_valid !== 1'b0 || editing !== 1'b1 || guess !== '0) begin fails++; $display("FAIL rst_offer got %b/%b/%h want 0/1/0", guess_valid, editing, guess); end
  endtask

  task automatic test_random();
    logic [NS*CW-1:0] eg;
    do_reset();
    foreach (m_slot[i]) m_slot[i] = 0;
    m_sel = 0; m_state = 0; m_dup_err = 0;
    for (int c = 0; c < 1500; c++) begin
      rst         = ($urandom_range(99) == 0);
      enable      = ($urandom_range(99) < 85);
      left        = ($urandom_range(5) == 0);
      right       = ($urandom_range(5) == 0);
      up          = ($urandom_range(3) == 0);
      down        = ($urandom_range(5) == 0);
      clear       = ($urandom_range(29) == 0);
      submit      = ($urandom_range(9) == 0);
      guess_ready = $urandom_range(1);
      result_done = ($urandom_range(7) == 0);
      m_step();
      tick();
      eg = '0;
      for (int i = 0; i < NS; i++) eg[i*CW +: CW] = CW'(m_slot[i]);
      tests++; if (guess !== eg) begin fails++; $display("FAIL rnd_guess cyc %0d got %h want %h", c, guess, eg); end
      tests++; if (sel !== SW'(m_sel)) begin fails++; $display("FAIL rnd_sel cyc %0d got %0d want %0d", c, sel, m_sel); end
      tests++; if (editing !== (m_state == 0) || guess_valid !== (m_state == 1)) begin
        fails++; $display("FAIL rnd_state cyc %0d got %b%b want %b%b", c, editing, guess_valid, m_state == 0, m_state == 1);
      end
      tests++; if (dup_err !== (m_dup_err != 0)) begin fails++; $display("FAIL rnd_duperr cyc %0d got %b want %0d", c, dup_err, m_dup_err); end
    end
    rst = 1'b0; idle_inputs(); guess_ready = 1'b0; enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; guess_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_cursor_wrap();
    test_color_wrap();
    test_combo();
    test_handshake();
    test_dup();
    test_clear_submit();
    test_reset_offer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
